// File: rtl/cpu_pkg.sv
// Shared definitions for the 64-bit pipelined ARM CPU datapath.
package cpu_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, load enable, synchronous clear.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // clr wins over en so a flush kills the slot even while the stage is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback select with XZR suppression,
// forwarding tap and retired-instruction counter.
module wb_stage #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              stall,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    logic [DATA_W-1:0] wb_data_p0;
    logic              v_p1;
    logic              rw_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  retire_cnt;

    // ---- p0: writeback mux ahead of the register so only DATA_W bits are stored
    assign wb_data_p0 = in_mem_to_reg ? in_mem_data : in_alu_result;

    pipe_reg #(.W(2 + ADDR_W)) u_ctrl_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~stall),
        .clr     (flush),
        .d       ({in_valid, in_reg_write, in_rd}),
        .q       ({v_p1, rw_p1, rd_p1})
    );

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~stall),
        .clr     (flush),
        .d       (wb_data_p0),
        .q       (data_p1)
    );

    // ---- p1: register-file write port, driven only from registered state
    assign wr_en   = v_p1 & rw_p1 & (rd_p1 != ADDR_W'(ZERO_REG));
    assign wr_sel  = wr_en ? rd_p1   : '0;
    assign wr_data = wr_en ? data_p1 : '0;

    assign fwd_valid = wr_en;
    assign fwd_rd    = wr_sel;
    assign fwd_data  = wr_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_cnt <= '0;
        end else if (v_p1 && !stall) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign retire_count = retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected WB outputs,
// a monitor pops and compares one entry per clock.
module tb_wb_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [4:0]  in_rd;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_data;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [63:0] wr_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [31:0] retire_count;

    typedef struct {
        string       name;
        logic        en;
        logic [4:0]  sel;
        logic [63:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    wb_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .stall         (stall),
        .flush         (flush),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string nm, input logic en_e, input logic [4:0] sel_e,
                             input logic [63:0] d_e, input logic [31:0] c_e);
        tests++;
        if ({wr_en, wr_sel, wr_data, fwd_valid, fwd_rd, fwd_data, retire_count} !==
            {en_e, sel_e, d_e, en_e, sel_e, d_e, c_e}) begin
            fails++;
            $display("FAIL %s: got en=%0b sel=%0d data=%h fwd=%0b/%0d/%h cnt=%h, want en=%0b sel=%0d data=%h cnt=%h",
                     nm, wr_en, wr_sel, wr_data, fwd_valid, fwd_rd, fwd_data, retire_count,
                     en_e, sel_e, d_e, c_e);
        end
    endtask

    // Monitor: one expected entry per clock after the edge that produced it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e.name, e.en, e.sel, e.data, e.cnt);
            end
        end
    end

    task automatic drive_push(input string nm, input logic v, input logic rw, input logic mtr,
                              input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem,
                              input logic st, input logic fl,
                              input logic en_e, input logic [4:0] sel_e,
                              input logic [63:0] d_e, input logic [31:0] c_e);
        exp_t e;
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = mtr;
        in_rd         = rd;
        in_alu_result = alu;
        in_mem_data   = mem;
        stall         = st;
        flush         = fl;
        e.name = nm;
        e.en   = en_e;
        e.sel  = sel_e;
        e.data = d_e;
        e.cnt  = c_e;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input logic v, input logic rw, input logic mtr,
                        input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem,
                        input logic st, input logic fl,
                        input logic en_e, input logic [4:0] sel_e,
                        input logic [63:0] d_e, input logic [31:0] c_e);
        @(negedge clk);
        drive_push(nm, v, rw, mtr, rd, alu, mem, st, fl, en_e, sel_e, d_e, c_e);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_reg_write = 0; in_mem_to_reg = 0; in_rd = '0;
        in_alu_result = '0; in_mem_data = '0; stall = 0; flush = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        idle_inputs();
        #12;
        check_now("reset_init", 0, 0, 64'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        //    name          v  rw mtr rd  alu                    mem        st fl  en sel data                   cnt
        step("alu_x5",      1, 1, 0,  5,  64'hDEAD_BEEF,         64'h0,     0, 0,  1, 5,  64'hDEAD_BEEF,         0);
        step("idle_cnt1",   0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 1);
        step("xzr_load",    1, 1, 1,  31, 64'h55,                64'h1234,  0, 0,  0, 0,  64'h0,                 1);
        step("alu_x7",      1, 1, 0,  7,  64'h77,                64'h0,     0, 0,  1, 7,  64'h77,                2);
        step("stall1",      1, 1, 0,  9,  64'h99,                64'h0,     1, 0,  1, 7,  64'h77,                2);
        step("stall2",      1, 1, 0,  9,  64'h99,                64'h0,     1, 0,  1, 7,  64'h77,                2);
        step("stall3",      1, 1, 0,  9,  64'h99,                64'h0,     1, 0,  1, 7,  64'h77,                2);
        step("unstall",     0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 3);
        step("b2b_x3_a",    1, 1, 0,  3,  64'hA1,                64'h0,     0, 0,  1, 3,  64'hA1,                3);
        step("b2b_x3_b",    1, 1, 1,  3,  64'h0,                 64'hB2,    0, 0,  1, 3,  64'hB2,                4);
        step("nowrite",     1, 0, 0,  3,  64'hC3,                64'h0,     0, 0,  0, 0,  64'h0,                 5);
        step("nowrite_cnt", 0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 6);
        step("pre_flush",   1, 1, 0,  10, 64'h10,                64'h0,     0, 0,  1, 10, 64'h10,                6);
        step("flush_stall", 1, 1, 0,  11, 64'h11,                64'h0,     1, 1,  0, 0,  64'h0,                 6);
        step("post_flush",  0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 6);
        step("flush_only",  1, 1, 0,  12, 64'h12,                64'h0,     0, 1,  0, 0,  64'h0,                 6);
        step("flush_idle",  0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 6);
        step("pre_reset",   1, 1, 0,  4,  64'h44,                64'h0,     0, 0,  1, 4,  64'h44,                6);

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("reset_mid", 0, 0, 64'h0, 32'h0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        drive_push("wrap_load", 1, 1, 0, 2, 64'h22, 64'h0, 0, 0, 1, 2, 64'h22, 32'hFFFF_FFFF);
        step("wrap_zero",   0, 0, 0,  0,  64'h0,                 64'h0,     0, 0,  0, 0,  64'h0,                 0);

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
